// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the sequence detector.
// Used by seq_detector and seq_shift_reg.
package seq_det_pkg;

    typedef enum logic {
        StSearch = 1'b0,
        StHold   = 1'b1
    } det_state_e;

    // Bits needed to hold values 0..value-1; elaboration-time use only.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_shift_reg.sv
// Symbol window: keeps the last LEN accepted symbols, oldest in the low bits,
// plus a saturating fill count. Exposes next-state values for same-edge compare.
module seq_shift_reg
    import seq_det_pkg::*;
#(
    parameter int unsigned SYM_W = 2,
    parameter int unsigned LEN   = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic                        clr,
    input  logic [SYM_W-1:0]            sym,
    output logic [LEN*SYM_W-1:0]        win_nxt,
    output logic [clog2(LEN+1)-1:0]     fill,
    output logic [clog2(LEN+1)-1:0]     fill_nxt
);

    localparam int unsigned FILL_W = clog2(LEN + 1);
    localparam int unsigned WIN_W  = LEN * SYM_W;

    logic [WIN_W-1:0] win_q;

    always_comb begin
        win_nxt  = win_q;
        fill_nxt = fill;
        if (clr) begin
            win_nxt  = '0;
            fill_nxt = '0;
        end else if (en) begin
            win_nxt = {sym, win_q[WIN_W-1:SYM_W]};
            if (fill != FILL_W'(LEN)) begin
                fill_nxt = fill + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_q <= '0;
            fill  <= '0;
        end else begin
            win_q <= win_nxt;
            fill  <= fill_nxt;
        end
    end

endmodule

// File: rtl/seq_detector.sv
// Sliding-window symbol sequence detector with pulse and sticky match modes.
// Define SEQ_DET_COUNT_EN to build the saturating match counter.
module seq_detector
    import seq_det_pkg::*;
#(
    parameter int unsigned SYM_W = 2,
    parameter int unsigned LEN   = 3,
    parameter int unsigned CNT_W = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [SYM_W-1:0]            sym,
    input  logic [LEN*SYM_W-1:0]        pattern,
    input  logic                        hold_en,
    output logic                        match,
    output logic [CNT_W-1:0]            match_cnt,
    output logic [clog2(LEN+1)-1:0]     fill
);

    localparam int unsigned FILL_W = clog2(LEN + 1);

    det_state_e             state_q, state_d;
    logic                   match_d;
    logic                   sym_zero;
    logic                   win_clr;
    logic                   hit;
    logic [LEN*SYM_W-1:0]   win_nxt;
    logic [FILL_W-1:0]      fill_nxt;

    assign sym_zero = (sym == '0);
    // An accepted zero while holding releases the detector and flushes the window.
    assign win_clr  = in_valid && (state_q == StHold) && sym_zero;

    seq_shift_reg #(
        .SYM_W (SYM_W),
        .LEN   (LEN)
    ) u_window (
        .clk      (clk),
        .reset    (reset),
        .en       (in_valid),
        .clr      (win_clr),
        .sym      (sym),
        .win_nxt  (win_nxt),
        .fill     (fill),
        .fill_nxt (fill_nxt)
    );

    // Compare against the window including the symbol sampled on this edge.
    assign hit = in_valid && (state_q == StSearch) &&
                 (fill_nxt == FILL_W'(LEN)) && (win_nxt == pattern);

    always_comb begin
        state_d = state_q;
        match_d = 1'b0;
        unique case (state_q)
            StSearch: begin
                if (hit) begin
                    match_d = 1'b1;
                    if (hold_en) begin
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                match_d = 1'b1;
                if (in_valid && (sym_zero || !hold_en)) begin
                    state_d = StSearch;
                    match_d = 1'b0;
                end
            end
            default: begin
                state_d = StSearch;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StSearch;
            match   <= 1'b0;
        end else begin
            state_q <= state_d;
            match   <= match_d;
        end
    end

`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (hit && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector.sv
// Directed bench for seq_detector with a queue-based reference model checked
// every cycle, plus hand-computed spot checks.
module tb_seq_detector;

    localparam int unsigned SYM_W = 2;
    localparam int unsigned LEN   = 3;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned FW    = $clog2(LEN + 1);
    localparam int          CNT_MAX = (1 << CNT_W) - 1;
`ifdef SEQ_DET_COUNT_EN
    localparam bit CE = 1'b1;
`else
    localparam bit CE = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   in_valid;
    logic [SYM_W-1:0]       sym;
    logic [LEN*SYM_W-1:0]   pattern;
    logic                   hold_en;
    logic                   match;
    logic [CNT_W-1:0]       match_cnt;
    logic [FW-1:0]          fill;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_on = 1'b0;

    seq_detector #(
        .SYM_W (SYM_W),
        .LEN   (LEN),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .sym       (sym),
        .pattern   (pattern),
        .hold_en   (hold_en),
        .match     (match),
        .match_cnt (match_cnt),
        .fill      (fill)
    );

    always #5 clk = ~clk;

    // Reference model: history of accepted symbols and a holding flag.
    logic [SYM_W-1:0] hist[$];
    bit m_hold;
    bit m_match;
    int m_cnt;

    function automatic bit model_hit();
        if (hist.size() != LEN) return 1'b0;
        for (int i = 0; i < LEN; i++) begin
            logic [SYM_W-1:0] p;
            p = pattern[i*SYM_W +: SYM_W];
            if (hist[i] != p) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            hist.delete();
            m_hold  = 1'b0;
            m_match = 1'b0;
            m_cnt   = 0;
        end else if (in_valid) begin
            if (m_hold) begin
                if (sym == 0) begin
                    hist.delete();
                    m_hold  = 1'b0;
                    m_match = 1'b0;
                end else begin
                    hist.push_back(sym);
                    if (hist.size() > LEN) void'(hist.pop_front());
                    m_hold  = hold_en;
                    m_match = hold_en;
                end
            end else begin
                hist.push_back(sym);
                if (hist.size() > LEN) void'(hist.pop_front());
                m_match = model_hit();
                if (m_match) begin
                    if (m_cnt < CNT_MAX) m_cnt++;
                    m_hold = hold_en;
                end
            end
        end else if (!m_hold) begin
            m_match = 1'b0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            int exp_fill;
            exp_fill = (hist.size() > LEN) ? LEN : hist.size();
            chk("model_match", int'(match), int'(m_match));
            chk("model_cnt", int'(match_cnt), CE ? m_cnt : 0);
            chk("model_fill", int'(fill), exp_fill);
        end
    end

    // Symbol applied at negedge, sampled on the next posedge; returns 1 after it.
    task automatic send(input int s);
        @(negedge clk);
        in_valid = 1'b1;
        sym      = SYM_W'(s);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rst_match", int'(match), 0);
        chk("rst_cnt", int'(match_cnt), 0);
        chk("rst_fill", int'(fill), 0);
        @(negedge clk);
        #1 reset = 1'b0;
    endtask

    function automatic logic [LEN*SYM_W-1:0] pat(input int a, input int b, input int c);
        return {SYM_W'(c), SYM_W'(b), SYM_W'(a)};
    endfunction

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        sym      = '0;
        hold_en  = 1'b0;
        pattern  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("init_match", int'(match), 0);
        chk("init_fill", int'(fill), 0);
        cmp_on = 1'b1;
        @(negedge clk);
        #1 reset = 1'b0;
        // All-zero pattern and window after reset must not hit.
        idle(2);
        chk("rel_match", int'(match), 0);

        // Pulse mode, 1,2,3
        pattern = pat(1, 2, 3);
        send(1); chk("p_fill1", int'(fill), 1);
        send(2); chk("p_match_early", int'(match), 0);
        send(3); chk("p_match", int'(match), 1);
        chk("p_cnt", int'(match_cnt), CE ? 1 : 0);
        chk("p_fill3", int'(fill), 3);
        idle(1); chk("p_drop", int'(match), 0);

        // Sticky mode, 1,2,3,1,2,3,0
        do_reset();
        hold_en = 1'b1;
        send(1); send(2); send(3); chk("s_match", int'(match), 1);
        send(1); chk("s_hold1", int'(match), 1);
        send(2); send(3); chk("s_hold2", int'(match), 1);
        chk("s_cnt", int'(match_cnt), CE ? 1 : 0);
        idle(2); chk("s_idle", int'(match), 1);
        send(0); chk("s_rel", int'(match), 0);
        chk("s_fill", int'(fill), 0);

        // Overlapping hits, pattern 1,1,1, five 1s
        do_reset();
        hold_en = 1'b0;
        pattern = pat(1, 1, 1);
        send(1); send(1); chk("o_m2", int'(match), 0);
        send(1); chk("o_m3", int'(match), 1);
        send(1); chk("o_m4", int'(match), 1);
        send(1); chk("o_m5", int'(match), 1);
        chk("o_cnt", int'(match_cnt), CE ? 3 : 0);
        idle(1); chk("o_drop", int'(match), 0);

        // Idle gaps mid-pattern
        do_reset();
        pattern = pat(1, 2, 3);
        send(1);
        idle(1); chk("g_fill_a", int'(fill), 1); chk("g_match_a", int'(match), 0);
        idle(1); chk("g_fill_b", int'(fill), 1);
        send(2); send(3); chk("g_match", int'(match), 1);

        // Reset mid-pattern discards 1,2
        do_reset();
        send(1); send(2);
        do_reset();
        send(3); chk("r_match", int'(match), 0);
        chk("r_fill", int'(fill), 1);

        // Counter saturation: five hits
        do_reset();
        pattern = pat(1, 1, 1);
        repeat (7) send(1);
        chk("sat_cnt", int'(match_cnt), CE ? 3 : 0);

        // hold_en dropped while holding takes effect on next accepted symbol
        do_reset();
        hold_en = 1'b1;
        pattern = pat(1, 2, 3);
        send(1); send(2); send(3);
        hold_en = 1'b0;
        idle(1); chk("h_keep", int'(match), 1);
        send(1); chk("h_exit", int'(match), 0);
        chk("h_fill", int'(fill), 3);
        send(2); send(3); chk("h_rehit", int'(match), 1);
        chk("h_cnt", int'(match_cnt), CE ? 2 : 0);

        // Pattern change keeps the window
        do_reset();
        send(1); send(2);
        pattern = pat(1, 2, 0);
        send(0); chk("c_match", int'(match), 1);

        idle(2);
        cmp_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_detector.md
SEQ_DETECTOR -- requirements
Module: seq_detector

Interface
REQ-001 The block SHALL have parameter SYM_W, default 2: symbol width in bits.
REQ-002 The block SHALL have parameter LEN, default 3, legal range 2..16: pattern length in symbols.
REQ-003 The block SHALL have parameter CNT_W, default 8: match counter width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: sym is sampled this edge.
REQ-007 The block SHALL have port sym, input, SYM_W bits: incoming symbol.
REQ-008 The block SHALL have port pattern, input, LEN*SYM_W bits: target sequence; bits [SYM_W-1:0] hold the first (oldest) symbol.
REQ-009 The block SHALL have port hold_en, input, 1 bit: 1 = sticky mode, 0 = pulse mode.
REQ-010 The block SHALL have port match, output, 1 bit: registered detection flag.
REQ-011 The block SHALL have port match_cnt, output, CNT_W bits: count of match events.
REQ-012 The block SHALL have port fill, output, clog2(LEN+1) bits: number of valid symbols held in the window.

Function
REQ-013 Only edges with in_valid=1 SHALL advance the window; on in_valid=0 edges, window, fill, state and match_cnt SHALL hold.
REQ-014 The window SHALL keep the last LEN accepted symbols; fill SHALL increment per accepted symbol and saturate at LEN.
REQ-015 A hit SHALL occur when, including the symbol sampled this edge, fill reaches LEN and the window equals pattern.
REQ-016 match SHALL go high in the cycle after the edge that samples the last pattern symbol, i.e. a latency of 1.
REQ-017 The FSM SHALL have exactly two states, SEARCH and HOLD; reset enters SEARCH.
REQ-018 In pulse mode (hold_en=0) the FSM SHALL stay in SEARCH, and match SHALL be high for exactly one cycle per hit.
REQ-019 In pulse mode an in_valid=0 cycle following a hit SHALL drop match.
REQ-020 In pulse mode overlapping hits SHALL all be detected.
REQ-021 In sticky mode (hold_en=1), a hit in SEARCH SHALL move the FSM to HOLD.
REQ-022 In HOLD, match SHALL stay high through in_valid=0 cycles and through any accepted nonzero symbol.
REQ-023 In HOLD, an accepted zero symbol SHALL return the FSM to SEARCH, clear match, and clear fill and the window.
REQ-024 In HOLD, no new hit SHALL be counted.
REQ-025 A change of hold_en while in HOLD SHALL take effect at the next accepted symbol; hold_en=0 there SHALL return the FSM to SEARCH.
REQ-026 A change of pattern SHALL take effect at the next compare and SHALL NOT clear the window.
REQ-027 match_cnt SHALL increment once per SEARCH hit and saturate at all ones, with no wrap-around.

Reset
REQ-028 reset=1 SHALL immediately force: state SEARCH, window 0, fill 0, match 0, match_cnt 0.
REQ-029 reset asserted mid-pattern SHALL discard the partial sequence.
REQ-030 Release of reset SHALL NOT by itself cause a hit.

Configuration
REQ-031 With SEQ_DET_COUNT_EN defined, the block SHALL implement the saturating match_cnt counter.
REQ-032 Without SEQ_DET_COUNT_EN, match_cnt SHALL be constant 0 and the block SHALL contain no counter flops.

Structure
REQ-033 A shared package seq_det_pkg SHALL hold the SEARCH/HOLD state encodings and the clog2 helper.
REQ-034 The window SHALL be a sub-module, seq_shift_reg, parametrised by SYM_W and LEN, with enable, clear and fill outputs.

Verification
REQ-035 Pulse mode, pattern 1,2,3, stream 1,2,3 -> match=1 for exactly one cycle after the 3 is sampled; match_cnt=1.
REQ-036 Sticky mode, pattern 1,2,3, stream 1,2,3,1,2,3,0 -> match=1 from after the first 3 until the 0 is sampled, then 0; match_cnt=1; fill=0.
REQ-037 Pulse mode, pattern 1,1,1, stream of five 1s -> match high on 3 consecutive cycles; match_cnt=3.
REQ-038 Stream 1, then 2 idle cycles, then 2,3 -> match after the 3; fill and match unchanged during the idle cycles.
REQ-039 Stream 1,2, then reset pulse, then 3 -> all outputs 0 during reset; no match after the 3; fill=1.
REQ-040 CNT_W=2 with SEQ_DET_COUNT_EN, 5 hits -> match_cnt=3 (saturated); same stimulus without the macro -> match_cnt=0 throughout.
